// File: rtl/up5bit_count_monitor_pkg.sv
// ----------------------------------------------------------------------------
// up5bit_count_monitor_pkg
//   Shared types and default sizes for the up-counter stream monitor.
//   - mon_state_e : tracking state of the monitor
//   - cls_e       : classification of a valid sample against the previous one
//   - DEF_*       : default parameter values for the monitor top
// ----------------------------------------------------------------------------
package up5bit_count_monitor_pkg;

    localparam int DEF_WIDTH    = 5;
    localparam int DEF_STAT_W   = 8;
    localparam int DEF_LOCK_CNT = 4;

    typedef enum logic [1:0] {
        MON_UNLOCKED = 2'd0,
        MON_ACQUIRE  = 2'd1,
        MON_LOCKED   = 2'd2
    } mon_state_e;

    typedef enum logic [1:0] {
        CLS_MATCH    = 2'd0,
        CLS_HOLD     = 2'd1,
        CLS_MISMATCH = 2'd2
    } cls_e;

endpackage

// File: rtl/up5bit_count_monitor_sat.sv
// ----------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter used for the monitor statistics.
//   Ports:
//     clk   - clock
//     reset - synchronous active-high reset
//     clr   - synchronous clear; wins over a coincident inc
//     inc   - increment request; ignored once the count is all-ones
//     cnt   - current count (W bits)
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/up5bit_count_monitor.sv
// ----------------------------------------------------------------------------
// up5bit_count_monitor
//   Checks that each valid sample of an up-counter is the previous sample + 1
//   (mod 2^WIDTH). Reports lock status, error pulses and saturating error /
//   wrap statistics. All outputs are registered.
//   Ports:
//     clk        - clock (same as the upstream counter)
//     reset      - synchronous active-high reset
//     src_reset  - upstream counter in reset; drops lock, samples ignored
//     cnt_valid  - cnt_in carries a valid sample
//     cnt_in     - sampled counter value
//     clr_stats  - clears err_count / wrap_count (and err_sticky)
//     locked     - LOCK_CNT consecutive increments seen
//     err_pulse  - one-cycle pulse on a violation while locked
//     err_count  - saturating violation count
//     wrap_count - saturating max->0 count while locked
//     last_value - most recent valid sample
//     err_sticky - (only with MON_STICKY_ERR_EN) latched error flag
//   Optional feature macro: MON_STICKY_ERR_EN
// ----------------------------------------------------------------------------
module up5bit_count_monitor
    import up5bit_count_monitor_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int STAT_W   = DEF_STAT_W,
    parameter int LOCK_CNT = DEF_LOCK_CNT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              src_reset,
    input  logic              cnt_valid,
    input  logic [WIDTH-1:0]  cnt_in,
    input  logic              clr_stats,
    output logic              locked,
    output logic              err_pulse,
    output logic [STAT_W-1:0] err_count,
    output logic [STAT_W-1:0] wrap_count,
    output logic [WIDTH-1:0]  last_value
`ifdef MON_STICKY_ERR_EN
    ,
    output logic              err_sticky
`endif
);

    localparam int RUN_W = $clog2(LOCK_CNT + 1);

    mon_state_e        state, state_n;
    logic [WIDTH-1:0]  prev, prev_n, last_n, exp_val;
    logic [RUN_W-1:0]  run, run_n, run_inc;
    logic              locked_n;
    logic              err_evt, wrap_evt;
    cls_e              cls;

    assign exp_val = prev + 1'b1;
    assign run_inc = run + 1'b1;

    always_comb begin
        if (cnt_in == exp_val)
            cls = CLS_MATCH;
        else if (cnt_in == prev)
            cls = CLS_HOLD;
        else
            cls = CLS_MISMATCH;
    end

    always_comb begin
        state_n  = state;
        prev_n   = prev;
        last_n   = last_value;
        run_n    = run;
        locked_n = locked;
        err_evt  = 1'b0;
        wrap_evt = 1'b0;
        if (src_reset) begin
            state_n  = MON_UNLOCKED;
            run_n    = '0;
            locked_n = 1'b0;
        end else if (cnt_valid) begin
            prev_n = cnt_in;
            last_n = cnt_in;
            unique case (state)
                MON_UNLOCKED: begin
                    run_n   = '0;
                    state_n = MON_ACQUIRE;
                end
                MON_ACQUIRE: begin
                    if (cls == CLS_MATCH) begin
                        run_n = run_inc;
                        if (run_inc == RUN_W'(LOCK_CNT)) begin
                            state_n  = MON_LOCKED;
                            locked_n = 1'b1;
                        end
                    end else if (cls == CLS_MISMATCH) begin
                        run_n = '0;
                    end
                end
                MON_LOCKED: begin
                    if (cls == CLS_MATCH) begin
                        // A match from all-ones can only land on zero: a wrap.
                        wrap_evt = (prev == {WIDTH{1'b1}});
                    end else if (cls == CLS_MISMATCH) begin
                        err_evt  = 1'b1;
                        locked_n = 1'b0;
                        run_n    = '0;
                        state_n  = MON_ACQUIRE;
                    end
                end
                default: state_n = MON_UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= MON_UNLOCKED;
            prev       <= '0;
            run        <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            last_value <= '0;
        end else begin
            state      <= state_n;
            prev       <= prev_n;
            run        <= run_n;
            locked     <= locked_n;
            err_pulse  <= err_evt;
            last_value <= last_n;
        end
    end

    sat_counter #(.W(STAT_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_stats),
        .inc   (err_evt),
        .cnt   (err_count)
    );

    sat_counter #(.W(STAT_W)) u_wrap_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_stats),
        .inc   (wrap_evt),
        .cnt   (wrap_count)
    );

`ifdef MON_STICKY_ERR_EN
    // A new error outranks a coincident clear.
    always_ff @(posedge clk) begin
        if (reset)
            err_sticky <= 1'b0;
        else if (err_evt)
            err_sticky <= 1'b1;
        else if (clr_stats)
            err_sticky <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_up5bit_count_monitor.sv
module tb_up5bit_count_monitor;

    localparam int W    = 5;
    localparam int SW   = 2;
    localparam int LC   = 4;
    localparam int NV   = 1 << W;
    localparam int SMAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          reset, src_reset, cnt_valid, clr_stats;
    logic [W-1:0]  cnt_in;
    logic          locked, err_pulse;
    logic [SW-1:0] err_count, wrap_count;
    logic [W-1:0]  last_value;
`ifdef MON_STICKY_ERR_EN
    logic          err_sticky;
`endif

    up5bit_count_monitor #(.WIDTH(W), .STAT_W(SW), .LOCK_CNT(LC)) dut (
        .clk        (clk),
        .reset      (reset),
        .src_reset  (src_reset),
        .cnt_valid  (cnt_valid),
        .cnt_in     (cnt_in),
        .clr_stats  (clr_stats),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_count  (err_count),
        .wrap_count (wrap_count),
        .last_value (last_value)
`ifdef MON_STICKY_ERR_EN
        ,
        .err_sticky (err_sticky)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: integer view of the rules. "tracking" means a
    // previous sample exists to compare against since the last (src_)reset.
    int m_tracking, m_run, m_locked, m_prev, m_last, m_err;
    int m_errc, m_wrapc, m_sticky;

    always @(posedge clk) begin
        if (reset) begin
            m_tracking = 0; m_run = 0; m_locked = 0; m_prev = 0; m_last = 0;
            m_err = 0; m_errc = 0; m_wrapc = 0; m_sticky = 0;
        end else if (src_reset) begin
            m_tracking = 0; m_run = 0; m_locked = 0; m_err = 0;
        end else begin
            int v;
            bit einc, winc;
            m_err = 0; einc = 0; winc = 0;
            if (cnt_valid) begin
                v = int'(cnt_in);
                if (!m_tracking) begin
                    m_tracking = 1;
                    m_run = 0;
                end else if (v == (m_prev + 1) % NV) begin
                    if (m_locked) begin
                        if (m_prev == NV - 1) winc = 1;
                    end else begin
                        m_run++;
                        if (m_run >= LC) m_locked = 1;
                    end
                end else if (v != m_prev) begin
                    if (m_locked) begin
                        m_err = 1; einc = 1; m_locked = 0;
                    end
                    m_run = 0;
                end
                m_prev = v;
                m_last = v;
            end
            if (einc && m_errc < SMAX) m_errc++;
            if (winc && m_wrapc < SMAX) m_wrapc++;
            if (clr_stats) begin m_errc = 0; m_wrapc = 0; end
            if (m_err) m_sticky = 1;
            else if (clr_stats) m_sticky = 0;
        end
    end

    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("locked",     locked,     m_locked);
            check("err_pulse",  err_pulse,  m_err);
            check("err_count",  err_count,  m_errc);
            check("wrap_count", wrap_count, m_wrapc);
            check("last_value", last_value, m_last);
`ifdef MON_STICKY_ERR_EN
            check("err_sticky", err_sticky, m_sticky);
`endif
        end
    end

    task automatic step(input bit v, input int val, input bit clr = 0, input bit srst = 0, input bit rst = 0);
        cnt_valid = v;
        cnt_in    = W'(val);
        clr_stats = clr;
        src_reset = srst;
        reset     = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) step(1, i % NV);
    endtask

    // Lock on base..base+4 then break the sequence once.
    task automatic err_once(input int base);
        feed(base, base + 4);
        step(1, (base + 10) % NV);
    endtask

    initial begin
        int pv;
        cnt_valid = 0; cnt_in = '0; clr_stats = 0; src_reset = 0; reset = 1;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk_en = 1;
        check("rst_locked", locked, 0);
        check("rst_errc", err_count, 0);
        check("rst_last", last_value, 0);
        check("rst_wrap", wrap_count, 0);

        // 1: acquire lock
        feed(0, 3);
        check("t1_not_yet", locked, 0);
        step(1, 4);
        check("t1_locked", locked, 1);
        check("t1_last", last_value, 4);
        check("t1_errc", err_count, 0);

        // 2: wrap while locked
        feed(5, 31);
        feed(0, 1);
        check("t2_wrap", wrap_count, 1);
        check("t2_locked", locked, 1);
        check("t2_errc", err_count, 0);

        // 3: error then relock
        feed(2, 10);
        step(1, 13);
        check("t3_pulse", err_pulse, 1);
        check("t3_errc", err_count, 1);
        check("t3_unlock", locked, 0);
        step(1, 14);
        check("t3_pulse_gone", err_pulse, 0);
        feed(15, 16);
        check("t3_acq", locked, 0);
        step(1, 17);
        check("t3_relock", locked, 1);

        // 4: upstream reset
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 1);
            check("t4_unlock", locked, 0);
            check("t4_nopulse", err_pulse, 0);
        end
        check("t4_last_kept", last_value, 17);
        feed(0, 4);
        check("t4_relock", locked, 1);
        check("t4_errc", err_count, 1);

        // 5: saturation and clear-vs-error
        err_once(5);
        err_once(20);
        err_once(0);
        check("t5_sat", err_count, 3);
        feed(20, 24);
        step(1, 30, 1);
        check("t5_clr", err_count, 0);
        check("t5_pulse", err_pulse, 1);
`ifdef MON_STICKY_ERR_EN
        check("t5_sticky", err_sticky, 1);
`endif

        // 6: holds with valid gaps
        feed(3, 7);
        check("t6_locked7", locked, 1);
        step(1, 7);
        step(0, 19);
        step(1, 7);
        step(0, 2);
        step(1, 8);
        check("t6_locked", locked, 1);
        check("t6_errc", err_count, 0);
        check("t6_last", last_value, 8);

        // Randomized phase
        pv = 8;
        for (int c = 0; c < 4000; c++) begin
            int r, val;
            bit v, clr, srst, rst;
            r = int'($urandom_range(0, 99));
            if (r < 75)      val = (pv + 1) % NV;
            else if (r < 87) val = pv;
            else             val = int'($urandom_range(0, NV - 1));
            v    = ($urandom_range(0, 99) < 80);
            srst = ($urandom_range(0, 99) < 2);
            clr  = !srst && ($urandom_range(0, 99) < 3);
            rst  = ($urandom_range(0, 999) < 4);
            step(v, val, clr, srst, rst);
            if (v) pv = val;
        end

        // Reset mid-operation
        feed(0, 6);
        step(1, 7, 0, 0, 1);
        check("mid_rst_locked", locked, 0);
        check("mid_rst_last", last_value, 0);
        check("mid_rst_errc", err_count, 0);
        check("mid_rst_wrap", wrap_count, 0);

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
